// File: rtl/mseq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mseq_pkg
// Description : Shared types and constants for the micro-sequencer:
//               control-word field positions, seq/csel encodings, state
//               enum, and the opcode dispatch map (DMAP).
// Revision    : 1.0 - initial release
// ============================================================================
package mseq_pkg;

  localparam int unsigned UADDR_W_DEF     = 5;
  localparam int unsigned MAX_UADDR_DEF   = 24;
  localparam int unsigned RESET_UADDR_DEF = 8;
  localparam int unsigned TRAP_UADDR_DEF  = 0;

  // Control word layout (29 bits, only the low 10 are sequencing fields)
  localparam int unsigned CWRD_W   = 29;
  localparam int unsigned NEXT_LSB = 0;
  localparam int unsigned NEXT_MSB = 4;
  localparam int unsigned SEQ_LSB  = 5;
  localparam int unsigned SEQ_MSB  = 6;
  localparam int unsigned CSEL_LSB = 7;
  localparam int unsigned CSEL_MSB = 8;
  localparam int unsigned LINK_BIT = 9;

  typedef enum logic [1:0] {
    SEQ_WAITMEM  = 2'b00,
    SEQ_COND     = 2'b01,
    SEQ_DISPATCH = 2'b10,
    SEQ_JUMP     = 2'b11
  } seq_e;

  typedef enum logic [1:0] {
    CSEL_Z   = 2'b00,
    CSEL_C   = 2'b01,
    CSEL_N   = 2'b10,
    CSEL_ONE = 2'b11
  } csel_e;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    WAIT   = 2'b01,
    HALTED = 2'b10
  } state_e;

  // Which rule the target selector applies this cycle
  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,  // decode seq field
    MODE_RELEASE = 2'b01,  // leaving WAIT: target = next
    MODE_RESUME  = 2'b10   // leaving HALTED: target = DMAP[opcode]
  } eval_mode_e;

  typedef struct packed {
    logic                   valid;
    logic [UADDR_W_DEF-1:0] uaddr;
  } dmap_entry_t;

  // Opcode dispatch map: opcodes 0-7 populated, 8-15 unmapped
  function automatic dmap_entry_t dmap_lookup(input logic [3:0] op);
    dmap_entry_t e;
    e = '{valid: 1'b0, uaddr: '0};
    case (op)
      4'd0:    e = '{valid: 1'b1, uaddr: 5'd1};
      4'd1:    e = '{valid: 1'b1, uaddr: 5'd9};
      4'd2:    e = '{valid: 1'b1, uaddr: 5'd12};
      4'd3:    e = '{valid: 1'b1, uaddr: 5'd15};
      4'd4:    e = '{valid: 1'b1, uaddr: 5'd16};
      4'd5:    e = '{valid: 1'b1, uaddr: 5'd17};
      4'd6:    e = '{valid: 1'b1, uaddr: 5'd19};
      4'd7:    e = '{valid: 1'b1, uaddr: 5'd21};
      default: e = '{valid: 1'b0, uaddr: '0};
    endcase
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mseq_next_addr.sv
`default_nettype none
// ============================================================================
// Module      : mseq_next_addr
// Description : Combinational micro-address target selection (jump, cond,
//               dispatch, wait-for-memory, stack pop) plus range check.
//               Optional 1-deep call stack enabled by MSEQ_CALL_STACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mseq_next_addr
  import mseq_pkg::*;
#(
  parameter int unsigned UADDR_W    = UADDR_W_DEF,
  parameter int unsigned MAX_UADDR  = MAX_UADDR_DEF,
  parameter int unsigned TRAP_UADDR = TRAP_UADDR_DEF
) (
  input  eval_mode_e         mode_i,
  input  seq_e               seq_i,
  input  csel_e              csel_i,
  input  logic               link_i,
  input  logic [UADDR_W-1:0] next_i,
  input  logic [UADDR_W-1:0] cur_i,
  input  logic [3:0]         opcode_i,
  input  logic               flag_z_i,
  input  logic               flag_c_i,
  input  logic               flag_n_i,
  input  logic               mem_ready_i,
  input  logic [UADDR_W-1:0] ret_i,
  input  logic               ret_valid_i,
  output logic [UADDR_W-1:0] target_o,
  output logic               illegal_o,
  output logic               range_err_o,
  output logic               stall_o,
  output logic               push_o,
  output logic               pop_o
);

  localparam logic [UADDR_W-1:0] C_MAX  = UADDR_W'(MAX_UADDR);
  localparam logic [UADDR_W-1:0] C_TRAP = UADDR_W'(TRAP_UADDR);
  localparam logic [UADDR_W-1:0] C_ONE  = UADDR_W'(1);

  dmap_entry_t        w_dmap;
  logic [UADDR_W-1:0] w_raw;
  logic               w_force_trap;
  logic               w_stack_err;
  logic               w_cond;
  logic               w_link_en;

  assign w_dmap = dmap_lookup(opcode_i);

`ifdef MSEQ_CALL_STACK_EN
  assign w_link_en = link_i;
`else
  // Without the call stack the link bit and return inputs carry no meaning
  logic w_unused_stack;
  assign w_link_en      = 1'b0;
  assign w_unused_stack = ^{link_i, ret_i, ret_valid_i};
`endif

  // Branch condition selected by csel
  always_comb begin
    w_cond = 1'b1;
    unique case (csel_i)
      CSEL_Z:  w_cond = flag_z_i;
      CSEL_C:  w_cond = flag_c_i;
      CSEL_N:  w_cond = flag_n_i;
      default: w_cond = 1'b1;
    endcase
  end

  // Raw target before range checking; trap requests bypass the range check
  always_comb begin
    w_raw        = cur_i;
    w_force_trap = 1'b0;
    w_stack_err  = 1'b0;
    illegal_o    = 1'b0;
    stall_o      = 1'b0;
    push_o       = 1'b0;
    pop_o        = 1'b0;
    unique case (mode_i)
      MODE_RELEASE: w_raw = next_i;
      MODE_RESUME: begin
        if (w_dmap.valid) begin
          w_raw = UADDR_W'(w_dmap.uaddr);
        end else begin
          w_force_trap = 1'b1;
          illegal_o    = 1'b1;
        end
      end
      default: begin
        unique case (seq_i)
          SEQ_JUMP: begin
            w_raw  = next_i;
            push_o = w_link_en;
          end
          SEQ_COND: w_raw = w_cond ? next_i : (cur_i + C_ONE);
          SEQ_DISPATCH: begin
            if (w_link_en) begin
              // Return through the stack instead of the opcode map
              pop_o = 1'b1;
              if (ret_valid_i) begin
                w_raw = ret_i;
              end else begin
                w_force_trap = 1'b1;
                w_stack_err  = 1'b1;
              end
            end else if (w_dmap.valid) begin
              w_raw = UADDR_W'(w_dmap.uaddr);
            end else begin
              w_force_trap = 1'b1;
              illegal_o    = 1'b1;
            end
          end
          default: begin
            // WAITMEM: proceed on ready, otherwise re-issue the current word
            if (mem_ready_i) begin
              w_raw = next_i;
            end else begin
              w_raw   = cur_i;
              stall_o = 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  // Replace unpopulated control-store targets with the trap word
  always_comb begin
    target_o    = w_raw;
    range_err_o = 1'b0;
    if (w_force_trap) begin
      target_o    = C_TRAP;
      range_err_o = w_stack_err;
    end else if (w_raw > C_MAX) begin
      target_o    = C_TRAP;
      range_err_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer
// Description : Next-micro-address generator for the microprogrammed control
//               unit. Holds the RUN/WAIT/HALTED state, the current address,
//               the pending-halt latch and sticky error flags.
//               Optional feature macro: MSEQ_CALL_STACK_EN (1-deep return
//               register for link JUMP / link DISPATCH).
// Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer
  import mseq_pkg::*;
#(
  parameter int unsigned UADDR_W     = UADDR_W_DEF,
  parameter int unsigned MAX_UADDR   = MAX_UADDR_DEF,
  parameter int unsigned RESET_UADDR = RESET_UADDR_DEF,
  parameter int unsigned TRAP_UADDR  = TRAP_UADDR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CWRD_W-1:0]  cwrd,
  input  logic [3:0]         opcode,
  input  logic               flag_z,
  input  logic               flag_c,
  input  logic               flag_n,
  input  logic               mem_ready,
  input  logic               halt_req,
  input  logic               run,
  output logic [UADDR_W-1:0] uaddr,
  output logic               halted,
  output logic               illegal_op,
  output logic               uaddr_err
);

  localparam logic [UADDR_W-1:0] C_RESET = UADDR_W'(RESET_UADDR);
  localparam logic [UADDR_W-1:0] C_TRAP  = UADDR_W'(TRAP_UADDR);

  state_e             state_q, state_d;
  logic [UADDR_W-1:0] cur_q;
  logic               pending_q, pending_d;
  logic               illegal_q, illegal_d;
  logic               uaddr_err_q, uaddr_err_d;

  logic [UADDR_W-1:0] w_next;
  seq_e               w_seq;
  csel_e              w_csel;
  logic               w_link;
  eval_mode_e         w_mode;
  logic               w_halt_entry;
  logic [UADDR_W-1:0] w_target;
  logic               w_illegal;
  logic               w_range_err;
  logic               w_stall;
  logic               w_push;
  logic               w_pop;
  logic [UADDR_W-1:0] w_ret;
  logic               w_ret_valid;
  logic               w_unused_cwrd;

  assign w_next        = cwrd[NEXT_MSB:NEXT_LSB];
  assign w_seq         = seq_e'(cwrd[SEQ_MSB:SEQ_LSB]);
  assign w_csel        = csel_e'(cwrd[CSEL_MSB:CSEL_LSB]);
  assign w_link        = cwrd[LINK_BIT];
  assign w_unused_cwrd = ^cwrd[CWRD_W-1:LINK_BIT+1];

  // A pending halt takes effect at the next dispatch boundary
  assign w_halt_entry = (state_q == RUN) && (w_seq == SEQ_DISPATCH) && pending_q;

  // Choose the target rule from the current state
  always_comb begin
    w_mode = MODE_RUN;
    unique case (state_q)
      WAIT:    w_mode = MODE_RELEASE;
      HALTED:  w_mode = MODE_RESUME;
      default: w_mode = MODE_RUN;
    endcase
  end

  mseq_next_addr #(
    .UADDR_W    (UADDR_W),
    .MAX_UADDR  (MAX_UADDR),
    .TRAP_UADDR (TRAP_UADDR)
  ) u_next_addr (
    .mode_i      (w_mode),
    .seq_i       (w_seq),
    .csel_i      (w_csel),
    .link_i      (w_link),
    .next_i      (w_next),
    .cur_i       (cur_q),
    .opcode_i    (opcode),
    .flag_z_i    (flag_z),
    .flag_c_i    (flag_c),
    .flag_n_i    (flag_n),
    .mem_ready_i (mem_ready),
    .ret_i       (w_ret),
    .ret_valid_i (w_ret_valid),
    .target_o    (w_target),
    .illegal_o   (w_illegal),
    .range_err_o (w_range_err),
    .stall_o     (w_stall),
    .push_o      (w_push),
    .pop_o       (w_pop)
  );

  // Next state, issued address and sticky-flag updates
  always_comb begin
    state_d     = state_q;
    uaddr       = w_target;
    pending_d   = pending_q | halt_req;
    illegal_d   = illegal_q;
    uaddr_err_d = uaddr_err_q;
    unique case (state_q)
      RUN: begin
        if (w_halt_entry) begin
          uaddr     = C_TRAP;
          state_d   = HALTED;
          pending_d = halt_req;
        end else begin
          illegal_d   = illegal_q | w_illegal;
          uaddr_err_d = uaddr_err_q | w_range_err;
          if (w_stall) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ready) begin
          uaddr_err_d = uaddr_err_q | w_range_err;
          state_d     = RUN;
        end else begin
          uaddr = cur_q;
        end
      end
      HALTED: begin
        if (run) begin
          illegal_d   = illegal_q | w_illegal;
          uaddr_err_d = uaddr_err_q | w_range_err;
          state_d     = RUN;
        end else begin
          uaddr = C_TRAP;
        end
      end
      default: begin
        uaddr   = C_TRAP;
        state_d = RUN;
      end
    endcase
    // Keep control_reg and the sequencer aligned on the reset word
    if (reset) begin
      uaddr = C_RESET;
    end
  end

  // State, current address, halt latch and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cur_q       <= C_RESET;
      pending_q   <= 1'b0;
      illegal_q   <= 1'b0;
      uaddr_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= uaddr;
      pending_q   <= pending_d;
      illegal_q   <= illegal_d;
      uaddr_err_q <= uaddr_err_d;
    end
  end

`ifdef MSEQ_CALL_STACK_EN
  localparam logic [UADDR_W-1:0] C_ONE = UADDR_W'(1);

  logic [UADDR_W-1:0] ret_q, ret_d;
  logic               ret_valid_q, ret_valid_d;

  assign w_ret       = ret_q;
  assign w_ret_valid = ret_valid_q;

  // Push return address on link JUMP, consume it on link DISPATCH
  always_comb begin
    ret_d       = ret_q;
    ret_valid_d = ret_valid_q;
    if ((state_q == RUN) && !w_halt_entry) begin
      if (w_push) begin
        ret_d       = cur_q + C_ONE;
        ret_valid_d = 1'b1;
      end else if (w_pop) begin
        ret_valid_d = 1'b0;
      end
    end
  end

  // Return register storage
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_q       <= '0;
      ret_valid_q <= 1'b0;
    end else begin
      ret_q       <= ret_d;
      ret_valid_q <= ret_valid_d;
    end
  end
`else
  logic w_unused_stack_ctl;
  assign w_ret              = '0;
  assign w_ret_valid        = 1'b0;
  assign w_unused_stack_ctl = w_push ^ w_pop;
`endif

  assign halted     = (state_q == HALTED);
  assign illegal_op = illegal_q;
  assign uaddr_err  = uaddr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_sequencer
// Description : Self-checking bench for micro_sequencer: directed scenarios
//               followed by randomized traffic, all compared against a
//               behavioural model of the sequencing rules.
//               Honours MSEQ_CALL_STACK_EN for the call-stack scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

  localparam int C_MAX   = 24;
  localparam int C_RESET = 8;
  localparam int C_TRAP  = 0;
  localparam int ST_RUN  = 0;
  localparam int ST_WAIT = 1;
  localparam int ST_HALT = 2;

  logic        clk;
  logic        reset;
  logic [28:0] cwrd;
  logic [3:0]  opcode;
  logic        flag_z, flag_c, flag_n;
  logic        mem_ready, halt_req, run;
  logic [4:0]  uaddr;
  logic        halted, illegal_op, uaddr_err;

  micro_sequencer u_dut (
    .clk        (clk),
    .reset      (reset),
    .cwrd       (cwrd),
    .opcode     (opcode),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_n     (flag_n),
    .mem_ready  (mem_ready),
    .halt_req   (halt_req),
    .run        (run),
    .uaddr      (uaddr),
    .halted     (halted),
    .illegal_op (illegal_op),
    .uaddr_err  (uaddr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Reference model state
  int dmap[8] = '{1, 9, 12, 15, 16, 17, 19, 21};
  int m_st = ST_RUN, m_cur = 0, m_ret = 0;
  bit m_pend = 0, m_ill = 0, m_err = 0, m_rv = 0, m_known = 0;
  int e_u;
  int n_st, n_cur, n_ret;
  bit n_pend, n_ill, n_err, n_rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic logic [28:0] mkw(input int sq, input int cs, input bit lk, input int nx);
    logic [18:0] hi;
    hi = 19'($urandom);
    return {hi, lk, 2'(cs), 2'(sq), 5'(nx)};
  endfunction

  // Expected address this cycle and model state after the coming edge
  task automatic model_comb();
    int nx, sq, cs, t;
    bit lk, cond, use_stack;
    nx = int'(cwrd[4:0]);
    sq = int'(cwrd[6:5]);
    cs = int'(cwrd[8:7]);
    lk = cwrd[9];
`ifdef MSEQ_CALL_STACK_EN
    use_stack = 1'b1;
`else
    use_stack = 1'b0;
`endif
    n_st = m_st; n_pend = m_pend | halt_req; n_ill = m_ill; n_err = m_err;
    n_ret = m_ret; n_rv = m_rv;
    t = -1;
    e_u = C_TRAP;
    if (reset) begin
      e_u = C_RESET; n_st = ST_RUN; n_pend = 0; n_ill = 0; n_err = 0; n_ret = 0; n_rv = 0;
    end else begin
      if (m_st == ST_RUN) begin
        if (sq == 2 && m_pend) begin
          e_u = C_TRAP; n_st = ST_HALT; n_pend = halt_req;
        end else if (sq == 3) begin
          t = nx;
          if (use_stack && lk) begin n_ret = (m_cur + 1) % 32; n_rv = 1; end
        end else if (sq == 1) begin
          cond = (cs == 0) ? flag_z : (cs == 1) ? flag_c : (cs == 2) ? flag_n : 1'b1;
          t = cond ? nx : (m_cur + 1) % 32;
        end else if (sq == 2) begin
          if (use_stack && lk) begin
            n_rv = 0;
            if (m_rv) t = m_ret;
            else begin e_u = C_TRAP; n_err = 1; end
          end else if (opcode < 8) t = dmap[opcode];
          else begin e_u = C_TRAP; n_ill = 1; end
        end else begin
          if (mem_ready) t = nx;
          else begin e_u = m_cur; n_st = ST_WAIT; end
        end
      end else if (m_st == ST_WAIT) begin
        if (mem_ready) begin t = nx; n_st = ST_RUN; end
        else e_u = m_cur;
      end else begin
        if (run) begin
          n_st = ST_RUN;
          if (opcode < 8) t = dmap[opcode];
          else begin e_u = C_TRAP; n_ill = 1; end
        end else e_u = C_TRAP;
      end
      if (t >= 0) begin
        if (t > C_MAX) begin e_u = C_TRAP; n_err = 1; end
        else e_u = t;
      end
    end
    n_cur = e_u;
  endtask

  // Mid-cycle sample and compare against the model
  task automatic eval_cycle();
    #3;
    model_comb();
    check("uaddr", uaddr, e_u);
    if (m_known) begin
      check("halted", halted, (m_st == ST_HALT));
      check("illegal_op", illegal_op, m_ill);
      check("uaddr_err", uaddr_err, m_err);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    m_st = n_st; m_cur = n_cur; m_pend = n_pend; m_ill = n_ill; m_err = n_err;
    m_ret = n_ret; m_rv = n_rv;
    if (reset) m_known = 1;
    cyc_n++;
  endtask

  task automatic cyc();
    eval_cycle();
    adv();
  endtask

  int cn[4] = '{10, 10, 20, 20};
  bit cz[4] = '{1, 0, 0, 1};
  int ce[4] = '{10, 10, 10, 20};

  initial begin
    reset = 1; cwrd = '0; opcode = '0; flag_z = 0; flag_c = 0; flag_n = 0;
    mem_ready = 0; halt_req = 0; run = 0;

    // Reset held three cycles
    repeat (3) begin
      eval_cycle(); check("rst_uaddr", uaddr, C_RESET); adv();
    end
    reset = 0; cwrd = mkw(3, 0, 0, 3);
    eval_cycle();
    check("jump_after_rst", uaddr, 3);
    check("rst_illegal", illegal_op, 0);
    check("rst_err", uaddr_err, 0);
    check("rst_halted", halted, 0);
    adv();

    // Conditional branch on Z from cur=9
    for (int i = 0; i < 4; i++) begin
      cwrd = mkw(3, 0, 0, 9); flag_z = 0; cyc();
      cwrd = mkw(1, 0, 0, cn[i]); flag_z = cz[i];
      eval_cycle(); check("cond_z", uaddr, ce[i]); adv();
    end

    // Wait for memory: hold 4 cycles then release
    cwrd = mkw(3, 0, 0, 5); mem_ready = 1; cyc();
    cwrd = mkw(0, 0, 0, 6); mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      eval_cycle(); check("wait_hold", uaddr, 5); adv();
    end
    mem_ready = 1;
    eval_cycle(); check("wait_release", uaddr, 6); adv();

    // Reset during WAIT
    cwrd = mkw(3, 0, 0, 5); cyc();
    cwrd = mkw(0, 0, 0, 6); mem_ready = 0; cyc(); cyc();
    reset = 1;
    eval_cycle(); check("wait_reset", uaddr, C_RESET); adv();
    reset = 0; cwrd = mkw(3, 0, 0, 4);
    eval_cycle(); check("post_reset_run", uaddr, 4); adv();

    // Dispatch valid / invalid opcodes, sticky illegal, range trap
    cwrd = mkw(2, 0, 0, 0); opcode = 2;
    eval_cycle(); check("disp_op2", uaddr, 12); adv();
    opcode = 9;
    eval_cycle(); check("disp_op9", uaddr, C_TRAP); adv();
    for (int i = 0; i < 10; i++) begin
      cwrd = mkw(3, 0, 0, int'($urandom_range(0, 24))); cyc();
    end
    cwrd = mkw(3, 0, 0, 27);
    eval_cycle(); check("illegal_sticky", illegal_op, 1); check("jump27", uaddr, C_TRAP); adv();
    cwrd = mkw(3, 0, 0, 1);
    eval_cycle(); check("err_sticky", uaddr_err, 1); adv();

    // Halt at dispatch boundary, then resume with run
    halt_req = 1; cwrd = mkw(3, 0, 0, 2); cyc();
    halt_req = 0; cwrd = mkw(2, 0, 0, 0); opcode = 3;
    eval_cycle(); check("halt_disp", uaddr, C_TRAP); adv();
    for (int i = 0; i < 5; i++) begin
      eval_cycle(); check("halted_hi", halted, 1); check("halt_uaddr", uaddr, C_TRAP); adv();
    end
    run = 1; opcode = 0;
    eval_cycle(); check("run_uaddr", uaddr, 1); adv();
    run = 0; cwrd = mkw(3, 0, 0, 2);
    eval_cycle(); check("run_halted_lo", halted, 0); adv();

`ifdef MSEQ_CALL_STACK_EN
    // Call / return through the 1-deep stack
    reset = 1; cyc(); reset = 0;
    cwrd = mkw(3, 0, 0, 5); cyc();
    cwrd = mkw(3, 0, 1, 13);
    eval_cycle(); check("push_jump", uaddr, 13); adv();
    cwrd = mkw(2, 0, 1, 0);
    eval_cycle(); check("pop", uaddr, 6); adv();
    eval_cycle(); check("pop_empty", uaddr, C_TRAP); adv();
    eval_cycle(); check("pop_empty_err", uaddr_err, 1); adv();
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      cwrd      = 29'($urandom);
      opcode    = 4'($urandom);
      flag_z    = 1'($urandom); flag_c = 1'($urandom); flag_n = 1'($urandom);
      mem_ready = ($urandom_range(0, 2) != 0);
      halt_req  = ($urandom_range(0, 19) == 0);
      run       = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
